// File: rtl/smd_sixbutton_reader_pkg.sv
// Shared definitions for the Mega Drive six-button pad reader.
// Button/pin/phase indices, FSM states and the sample-bank decoder.
package smd_sixbutton_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEQ,
    ST_DONE
  } state_e;

  localparam int NUM_BTN   = 12;
  localparam int NUM_PIN   = 6;
  localparam int NUM_PHASE = 8;

  localparam int BTN_UP = 0;
  localparam int BTN_DW = 1;
  localparam int BTN_LF = 2;
  localparam int BTN_RG = 3;
  localparam int BTN_A  = 4;
  localparam int BTN_B  = 5;
  localparam int BTN_C  = 6;
  localparam int BTN_ST = 7;
  localparam int BTN_X  = 8;
  localparam int BTN_Y  = 9;
  localparam int BTN_Z  = 10;
  localparam int BTN_MD = 11;

  localparam int PIN_P9 = 0;
  localparam int PIN_P6 = 1;
  localparam int PIN_P4 = 2;
  localparam int PIN_P3 = 3;
  localparam int PIN_P2 = 4;
  localparam int PIN_P1 = 5;

  localparam int PH_BASE = 0;
  localparam int PH_ID   = 1;
  localparam int PH_SIX  = 5;
  localparam int PH_EXT  = 6;
  localparam logic [2:0] PH_LAST = 3'd7;

  typedef logic [NUM_PIN-1:0] pins_t;
  typedef logic [NUM_PHASE-1:0][NUM_PIN-1:0] bank_t;

  typedef struct packed {
    logic [NUM_BTN-1:0] buttons;
    logic               present;
    logic               six_btn;
  } pad_state_t;

  // Pins are active low; a pressed button reads 0.
  function automatic pad_state_t decode(input bank_t s);
    pad_state_t r;
    r = '0;
    r.present = ~s[PH_ID][PIN_P3] & ~s[PH_ID][PIN_P4];
    r.six_btn = r.present
              & ~s[PH_SIX][PIN_P1] & ~s[PH_SIX][PIN_P2]
              & ~s[PH_SIX][PIN_P3] & ~s[PH_SIX][PIN_P4];
    if (r.present) begin
      r.buttons[BTN_UP] = ~s[PH_BASE][PIN_P1];
      r.buttons[BTN_DW] = ~s[PH_BASE][PIN_P2];
      r.buttons[BTN_LF] = ~s[PH_BASE][PIN_P3];
      r.buttons[BTN_RG] = ~s[PH_BASE][PIN_P4];
      r.buttons[BTN_B]  = ~s[PH_BASE][PIN_P6];
      r.buttons[BTN_C]  = ~s[PH_BASE][PIN_P9];
      r.buttons[BTN_A]  = ~s[PH_ID][PIN_P6];
      r.buttons[BTN_ST] = ~s[PH_ID][PIN_P9];
      if (r.six_btn) begin
        r.buttons[BTN_Z]  = ~s[PH_EXT][PIN_P1];
        r.buttons[BTN_Y]  = ~s[PH_EXT][PIN_P2];
        r.buttons[BTN_X]  = ~s[PH_EXT][PIN_P3];
        r.buttons[BTN_MD] = ~s[PH_EXT][PIN_P4];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/smd_sixbutton_reader_pin_sync.sv
// smd_pin_sync: 2-flop synchroniser for the asynchronous pad pins.
// Ports: i_clk clock, i_d async pins in, o_q synchronised pins out.
module smd_pin_sync #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    r_meta <= i_d;
    r_sync <= r_meta;
  end

  assign o_q = r_sync;

endmodule

// File: rtl/smd_sixbutton_reader.sv
// Console-side Mega Drive six-button pad reader: walks TH through eight
// phases per frame, samples the pins and decodes a 12-button vector.
// Ports: clk, rst_n (sync, low), en poll enable, p_in {p1,p2,p3,p4,p6,p9}
// active low; th select line, buttons pressed=1, present, six_btn, valid.
module smd_sixbutton_reader
  import smd_sixbutton_reader_pkg::*;
#(
  parameter int HALF_PERIOD   = 130,
  parameter int SETTLE_CYCLES = 20,
  parameter int FRAME_CYCLES  = 166000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [5:0]   p_in,
  output logic         th,
  output logic [11:0]  buttons,
  output logic         present,
  output logic         six_btn,
  output logic         valid
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST   = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] CYC_SAMPLE = CW'(SETTLE_CYCLES);
  localparam logic [FW-1:0] FRM_LAST   = FW'(FRAME_CYCLES - 1);

  state_e      r_state;
  state_e      w_state_nx;
  logic [2:0]  r_phase;
  logic [2:0]  w_phase_nx;
  logic [CW-1:0] r_cyc;
  logic [CW-1:0] w_cyc_nx;
  logic [FW-1:0] r_frame;
  logic [FW-1:0] w_frame_nx;
  logic        w_sample_en;
  logic        w_done;
  logic        w_th_nx;
  logic        r_th;
  logic        r_valid;
  pins_t       w_pins;
  bank_t       r_sample;
  pad_state_t  w_dec;
  pad_state_t  r_out;

  smd_pin_sync #(
    .W (NUM_PIN)
  ) u_sync (
    .i_clk (clk),
    .i_d   (p_in),
    .o_q   (w_pins)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_phase_nx  = r_phase;
    w_cyc_nx    = r_cyc;
    w_frame_nx  = r_frame;
    w_sample_en = 1'b0;
    w_done      = 1'b0;
    if (!en) begin
      // Dropping en aborts any sequence and parks the frame timer.
      w_state_nx = ST_IDLE;
      w_phase_nx = '0;
      w_cyc_nx   = '0;
      w_frame_nx = '0;
    end else begin
      // Frame timer free-runs through SEQ so starts stay periodic.
      w_frame_nx = (r_frame == FRM_LAST) ? '0 : r_frame + 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (r_frame == FRM_LAST) begin
            w_state_nx = ST_SEQ;
            w_phase_nx = '0;
            w_cyc_nx   = '0;
          end
        end
        ST_SEQ: begin
          w_sample_en = (r_cyc == CYC_SAMPLE);
          if (r_cyc == CYC_LAST) begin
            w_cyc_nx = '0;
            if (r_phase == PH_LAST) begin
              w_state_nx = ST_DONE;
            end else begin
              w_phase_nx = r_phase + 3'd1;
            end
          end else begin
            w_cyc_nx = r_cyc + 1'b1;
          end
        end
        ST_DONE: begin
          w_done     = 1'b1;
          w_state_nx = ST_IDLE;
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // TH is registered from the next state so the pad never sees a glitch.
  assign w_th_nx = ~((w_state_nx == ST_SEQ) & w_phase_nx[0]);
  assign w_dec   = decode(r_sample);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_cyc   <= '0;
      r_frame <= '0;
      r_th    <= 1'b1;
      r_valid <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
      r_cyc   <= w_cyc_nx;
      r_frame <= w_frame_nx;
      r_th    <= w_th_nx;
      r_valid <= w_done;
      if (w_done) begin
        r_out <= w_dec;
      end
    end
  end

  // Every used slot is rewritten before DONE, so the bank needs no reset.
  always_ff @(posedge clk) begin
    if (w_sample_en) begin
      r_sample[r_phase] <= w_pins;
    end
  end

  assign th      = r_th;
  assign buttons = r_out.buttons;
  assign present = r_out.present;
  assign six_btn = r_out.six_btn;
  assign valid   = r_valid;

endmodule

// File: tb/tb_smd_sixbutton_reader.sv
// Directed bench for smd_sixbutton_reader with a behavioural pad model.
// Shortened timing parameters keep each frame a few hundred cycles.
module tb_smd_sixbutton_reader;

  localparam int H   = 16;
  localparam int S   = 6;
  localparam int F   = 400;
  localparam int LAT = F + 8 * H + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [5:0]  p_in;
  logic        th;
  logic [11:0] buttons;
  logic        present;
  logic        six_btn;
  logic        valid;

  always #5 clk = ~clk;

  smd_sixbutton_reader #(
    .HALF_PERIOD   (H),
    .SETTLE_CYCLES (S),
    .FRAME_CYCLES  (F)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .p_in    (p_in),
    .th      (th),
    .buttons (buttons),
    .present (present),
    .six_btn (six_btn),
    .valid   (valid)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pad model: kind 0 none, 1 six-button, 2 three-button.
  int          kind = 0;
  logic [11:0] held = '0;
  logic        th_d = 1'b1;
  int          pcnt = 0;
  int          hicnt = 0;

  always @(posedge clk) begin
    th_d <= th;
    if (th_d && !th) pcnt <= pcnt + 1;
    if (th) begin
      hicnt <= hicnt + 1;
      if (hicnt >= 64) pcnt <= 0;
    end else begin
      hicnt <= 0;
    end
  end

  function automatic logic [5:0] pad_pins(input int k, input logic [11:0] b,
                                          input logic t, input int c);
    logic [5:0]  r;
    logic [11:0] n;
    n = ~b;
    r = 6'h3F;
    if (k != 0) begin
      if (t) begin
        if (k == 1 && c == 3) r = {n[10], n[9], n[8], n[11], n[5], n[6]};
        else                  r = {n[0], n[1], n[2], n[3], n[5], n[6]};
      end else begin
        if (k == 1 && c == 3)      r = {4'b0000, n[4], n[7]};
        else if (k == 1 && c == 4) r = {4'b1111, n[4], n[7]};
        else                       r = {n[0], n[1], 2'b00, n[4], n[7]};
      end
    end
    return r;
  endfunction

  always_comb p_in = pad_pins(kind, held, th, pcnt);

  // Monitor: valid pulses, TH falls and optional TH timing checks.
  int   vcount = 0;
  int   vcyc = 0;
  int   falls = 0;
  int   ffr = 0;
  int   last_fall = 0;
  bit   tm_en = 1'b0;
  logic th_n = 1'b1;

  always @(negedge clk) begin
    if (th_n && !th) begin
      falls++;
      if (tm_en && ffr > 0) chk("th_fall_gap", cyc - last_fall, 2 * H);
      ffr++;
      last_fall = cyc;
    end
    if (!th_n && th && tm_en) chk("th_low_len", cyc - last_fall, H);
    th_n = th;
    if (valid) begin
      vcount++;
      vcyc = cyc;
      if (tm_en) chk("th_falls_frame", ffr, 4);
      ffr = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (valid) ok = 1'b1;
    end
    chk(tag, ok, 1);
  endtask

  task automatic wait_falls(input string tag, input int n, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (falls >= n) ok = 1'b1;
    end
    chk(tag, ok, 1);
  endtask

  task automatic chk_out(input string tag, input logic [11:0] b,
                         input logic p, input logic s);
    chk({tag, "_buttons"}, buttons, b);
    chk({tag, "_present"}, present, p);
    chk({tag, "_six"}, six_btn, s);
  endtask

  int c0;
  int v0;
  int f0;
  int t1;

  initial begin
    // Reset, then idle with en low.
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_th", th, 1);
    chk("rst_valid", valid, 0);
    chk_out("rst", 12'h000, 1'b0, 1'b0);
    v0 = vcount;
    f0 = falls;
    repeat (F + 200) tick();
    chk("idle_no_valid", vcount - v0, 0);
    chk("idle_no_th_fall", falls - f0, 0);

    // Six-button pad, up+y; first frame latency from en rising.
    kind = 1;
    held = 12'h201;
    en = 1'b1;
    c0 = cyc;
    wait_valid("six_valid", LAT + 10);
    chk("six_latency", vcyc - c0, LAT);
    chk_out("six", 12'h201, 1'b1, 1'b1);
    tick();
    chk("valid_one_cycle", valid, 0);

    // Three-button pad, a+st.
    kind = 2;
    held = 12'h090;
    wait_valid("three_valid", 2 * F);
    chk_out("three", 12'h090, 1'b1, 1'b0);

    // Six-button pad, rg+b+x+z+md.
    kind = 1;
    held = 12'hD28;
    wait_valid("six2_valid", 2 * F);
    chk_out("six2", 12'hD28, 1'b1, 1'b1);

    // Three-button pad with up+down aliases as six-button.
    kind = 2;
    held = 12'h003;
    wait_valid("alias_valid", 2 * F);
    chk_out("alias", 12'h603, 1'b1, 1'b1);

    // No pad: strobes every frame with cleared state.
    kind = 0;
    held = 12'h000;
    wait_valid("nopad_valid1", 2 * F);
    chk_out("nopad1", 12'h000, 1'b0, 1'b0);
    t1 = vcyc;
    wait_valid("nopad_valid2", 2 * F);
    chk("frame_period", vcyc - t1, F);
    chk_out("nopad2", 12'h000, 1'b0, 1'b0);

    // TH timing over one full frame.
    kind = 1;
    held = 12'h201;
    wait_valid("tm_pre_valid", 2 * F);
    t1 = vcyc;
    tm_en = 1'b1;
    wait_valid("tm_valid", 2 * F);
    tm_en = 1'b0;
    chk("tm_period", vcyc - t1, F);
    chk_out("tm", 12'h201, 1'b1, 1'b1);

    // en dropped during phase 3: abort, outputs held.
    held = 12'hD28;
    falls = 0;
    wait_falls("abort_reach_ph3", 2, 2 * F);
    repeat (3) tick();
    en = 1'b0;
    tick();
    chk("abort_th", th, 1);
    chk("abort_valid", valid, 0);
    v0 = vcount;
    repeat (2 * F) tick();
    chk("abort_no_valid", vcount - v0, 0);
    chk_out("abort_hold", 12'h201, 1'b1, 1'b1);
    en = 1'b1;
    wait_valid("reen_valid", LAT + 10);
    chk_out("reen", 12'hD28, 1'b1, 1'b1);

    // Reset during phase 5: abort, outputs cleared.
    falls = 0;
    wait_falls("rst_reach_ph5", 3, 2 * F);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_th", th, 1);
    chk("midrst_valid", valid, 0);
    chk_out("midrst", 12'h000, 1'b0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    v0 = vcount;
    repeat (F) tick();
    chk("midrst_no_valid", vcount - v0, 0);
    wait_valid("post_rst_valid", LAT);
    chk_out("post_rst", 12'hD28, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
